// File: rtl/cmp_vector_sequencer.sv
// -----------------------------------------------------------------------------
// cmp_vector_sequencer
//
// Self-checking stimulus engine for a WIDTH-bit equals/not-equals comparator
// with a mode mux. It sweeps every {select, a, b} combination and drives each
// one onto dut_a/dut_b/dut_select. It then samples the comparator's bitwise
// and logical results and checks them against an internal golden model. Pass
// or fail, an error count and the first failing vector are reported.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   start           in   one-cycle pulse; begins a sweep when not busy
//   dut_a           out  [WIDTH-1:0]   operand a to the comparator
//   dut_b           out  [WIDTH-1:0]   operand b to the comparator
//   dut_select      out  0 = equals mode, 1 = not-equals mode
//   dut_bitwise     in   [WIDTH-1:0]   comparator bitwise result
//   dut_logical     in   comparator logical result
//   busy            out  sweep in progress
//   done            out  sweep complete; held until the next start or reset
//   pass            out  done && err_count == 0
//   err_count       out  [2*WIDTH+1:0] number of failing vectors
//   vec_index       out  [2*WIDTH:0]   current vector {select, a, b}
//   first_err_vec   out  [2*WIDTH:0]   index of the first failing vector
//   first_err_valid out  at least one failure captured
//   dbg_state_o     out  [2:0]         current FSM state (IDLE=0 .. DONE=4)
//
// Start protocol: start is sampled on each rising edge. It is acted on only
// in IDLE or DONE. While a sweep runs it is ignored. No acknowledge is
// returned; busy rising on the same edge shows that the start was accepted.
//
// Per-vector timing: DRIVE takes 1 cycle and WAIT takes SETTLE cycles. The
// DUT response is registered every cycle. CHECK therefore compares the value
// the DUT presented in the last WAIT cycle. That cycle is SETTLE cycles after
// the vector first appeared. Each vector takes SETTLE+2 cycles in total.
// -----------------------------------------------------------------------------
module cmp_vector_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_select,
  input  logic [WIDTH-1:0]     dut_bitwise,
  input  logic                 dut_logical,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     vec_index,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic                 first_err_valid,
  output logic [2:0]           dbg_state_o
);

  localparam int VW  = 2*WIDTH + 1;
  localparam int CW  = 2*WIDTH + 2;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [VW-1:0]  LAST_VEC    = {VW{1'b1}};
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    err_q, err_d;
  logic [VW-1:0]    ferr_vec_q, ferr_vec_d;
  logic             ferr_valid_q, ferr_valid_d;
  logic [WIDTH-1:0] resp_bw_q;
  logic             resp_lg_q;

  // Golden model for the vector currently held in vec_q.
  logic             cur_sel;
  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [WIDTH-1:0] exp_bw;
  logic             exp_lg;
  logic             mismatch;

  assign cur_sel = vec_q[VW-1];
  assign cur_a   = vec_q[2*WIDTH-1:WIDTH];
  assign cur_b   = vec_q[WIDTH-1:0];

  always_comb begin
    if (cur_sel) begin
      exp_bw = cur_a ^ cur_b;
      exp_lg = (cur_a != cur_b);
    end else begin
      exp_bw = ~(cur_a ^ cur_b);
      exp_lg = (cur_a == cur_b);
    end
  end

  // A bitwise and a logical mismatch on the same vector count as a single
  // failure.
  assign mismatch = (resp_bw_q != exp_bw) || (resp_lg_q != exp_lg);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      ferr_vec_q   <= '0;
      ferr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ferr_vec_q   <= ferr_vec_d;
      ferr_valid_q <= ferr_valid_d;
    end
  end

  // The response is captured every cycle. CHECK then sees a value that was
  // stable one full cycle before the compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_bw_q <= '0;
      resp_lg_q <= 1'b0;
    end else begin
      resp_bw_q <= dut_bitwise;
      resp_lg_q <= dut_logical;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    ferr_vec_d   = ferr_vec_q;
    ferr_valid_d = ferr_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Results stay visible in DONE until a new sweep is requested.
        if (start) begin
          state_d      = S_DRIVE;
          vec_d        = '0;
          err_d        = '0;
          ferr_vec_d   = '0;
          ferr_valid_d = 1'b0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_DRIVE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + SCW'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + CW'(1);
          if (!ferr_valid_q) begin
            ferr_vec_d   = vec_q;
            ferr_valid_d = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The operands are fields of the registered vector index. They stay stable
  // from DRIVE through CHECK.
  assign dut_select      = vec_q[VW-1];
  assign dut_a           = vec_q[2*WIDTH-1:WIDTH];
  assign dut_b           = vec_q[WIDTH-1:0];

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_q == '0);
  assign err_count       = err_q;
  assign vec_index       = vec_q;
  assign first_err_vec   = ferr_vec_q;
  assign first_err_valid = ferr_valid_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cmp_vector_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for cmp_vector_sequencer. The main instance (SETTLE=1) faces a
// behavioural comparator. A mode variable selects how that comparator behaves:
//   0 correct, 1 bitwise[0] stuck at 0, 2 logical inverted, 3 two-cycle
//   registered.
// A second instance (SETTLE=3) always faces a two-cycle registered comparator.
// -----------------------------------------------------------------------------
module tb_cmp_vector_sequencer;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (SETTLE=1) ----------------
  logic         start = 1'b0;
  logic [W-1:0] dut_a, dut_b;
  logic         dut_select;
  logic [W-1:0] dut_bitwise;
  logic         dut_logical;
  logic         busy, done, pass, first_err_valid;
  logic [2*W+1:0] err_count;
  logic [2*W:0]   vec_index, first_err_vec;
  logic [2:0]     dbg_state;

  cmp_vector_sequencer #(.WIDTH(W), .SETTLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_select(dut_select),
    .dut_bitwise(dut_bitwise), .dut_logical(dut_logical),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_index(vec_index), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid), .dbg_state_o(dbg_state)
  );

  // ---------------- second DUT (SETTLE=3) ----------------
  logic         start3 = 1'b0;
  logic [W-1:0] a3, b3;
  logic         sel3;
  logic [W-1:0] bw3;
  logic         lg3;
  logic         busy3, done3, pass3, fev_valid3;
  logic [2*W+1:0] err3;
  logic [2*W:0]   vec3, fev3;
  logic [2:0]     dbg_state3;

  cmp_vector_sequencer #(.WIDTH(W), .SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_select(sel3),
    .dut_bitwise(bw3), .dut_logical(lg3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .vec_index(vec3), .first_err_vec(fev3),
    .first_err_valid(fev_valid3), .dbg_state_o(dbg_state3)
  );

  // ---------------- comparator models ----------------
  // Returns {bitwise[3:0], logical}.
  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic s);
    if (s) return {a ^ b, (a != b)};
    else   return {~(a ^ b), (a == b)};
  endfunction

  int unsigned mode = 0;
  logic [W:0]  comb_r;
  logic [W:0]  p1, p2, q1, q2;

  always @(posedge clk) begin
    p1 <= model(dut_a, dut_b, dut_select);
    p2 <= p1;
    q1 <= model(a3, b3, sel3);
    q2 <= q1;
  end

  always_comb begin
    comb_r      = model(dut_a, dut_b, dut_select);
    dut_bitwise = comb_r[W:1];
    dut_logical = comb_r[0];
    case (mode)
      1: dut_bitwise = {comb_r[W:2], 1'b0};
      2: dut_logical = ~comb_r[0];
      3: begin
        dut_bitwise = p2[W:1];
        dut_logical = p2[0];
      end
      default: ;
    endcase
  end

  assign bw3 = q2[W:1];
  assign lg3 = q2[0];

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start on one instance and count cycles from the start edge to done.
  task automatic run_sweep(input bit which, input int limit, output int cycles);
    @(negedge clk);
    if (which) start3 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start3 = 1'b0;
    cycles = 0;
    while (((which ? done3 : done) !== 1'b1) && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({busy, done, pass, first_err_valid, dut_select} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, done, pass, first_err_valid, dut_select});
    else passed++;
    checks++;
    if ({dut_a, dut_b, err_count, vec_index, first_err_vec} !== '0)
      $display("FAIL reset_values: a=%0d b=%0d err=%0d vec=%0d fev=%0d expected all 0",
               dut_a, dut_b, err_count, vec_index, first_err_vec);
    else passed++;
    apply_reset();
  endtask

  task automatic test_full_pass();
    int cyc;
    mode = 0;
    run_sweep(1'b0, 4000, cyc);
    checks++;
    if (cyc != 1536) $display("FAIL pass_len: got %0d cycles expected 1536", cyc);
    else passed++;
    checks++;
    if ({done, pass, busy, first_err_valid} !== 4'b1100)
      $display("FAIL pass_flags: got done/pass/busy/fev=%b expected 1100",
               {done, pass, busy, first_err_valid});
    else passed++;
    checks++;
    if (err_count !== 10'd0) $display("FAIL pass_err: got %0d expected 0", err_count);
    else passed++;
    checks++;
    if (vec_index !== 9'd511) $display("FAIL pass_vec: got %0d expected 511", vec_index);
    else passed++;
    apply_reset();
  endtask

  task automatic test_bit0_stuck();
    int cyc;
    mode = 1;
    run_sweep(1'b0, 4000, cyc);
    checks++;
    if (err_count !== 10'd256) $display("FAIL bit0_err: got %0d expected 256", err_count);
    else passed++;
    checks++;
    if (first_err_vec !== 9'd0 || first_err_valid !== 1'b1)
      $display("FAIL bit0_first: got vec=%0d valid=%b expected vec=0 valid=1",
               first_err_vec, first_err_valid);
    else passed++;
    checks++;
    if (pass !== 1'b0 || done !== 1'b1)
      $display("FAIL bit0_pass: got pass=%b done=%b expected pass=0 done=1", pass, done);
    else passed++;
    apply_reset();
  endtask

  task automatic test_logical_inverted();
    int cyc;
    mode = 2;
    run_sweep(1'b0, 4000, cyc);
    checks++;
    if (err_count !== 10'd512) $display("FAIL inv_err: got %0d expected 512", err_count);
    else passed++;
    checks++;
    if (first_err_vec !== 9'd0 || pass !== 1'b0)
      $display("FAIL inv_first: got vec=%0d pass=%b expected vec=0 pass=0",
               first_err_vec, pass);
    else passed++;
    apply_reset();
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || vec_index === 9'd0)
      $display("FAIL mid_running: got busy=%b vec=%0d expected busy=1 vec>0", busy, vec_index);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, first_err_valid, dut_select, dut_a, dut_b,
         err_count, vec_index, first_err_vec} !== '0)
      $display("FAIL mid_async_clear: busy=%b vec=%0d a=%0d b=%0d err=%0d expected all 0",
               busy, vec_index, dut_a, dut_b, err_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    run_sweep(1'b0, 4000, cyc);
    checks++;
    if (cyc != 1536 || pass !== 1'b1)
      $display("FAIL mid_rerun: got %0d cycles pass=%b expected 1536 pass=1", cyc, pass);
    else passed++;
    apply_reset();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == 10 || cyc == 500);
    end
    start = 1'b0;
    checks++;
    if (cyc != 1536) $display("FAIL busy_start_len: got %0d cycles expected 1536", cyc);
    else passed++;
    checks++;
    if (err_count !== 10'd256) $display("FAIL busy_start_err: got %0d expected 256", err_count);
    else passed++;
    // A start seen in DONE clears the results and begins a new sweep.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || err_count !== 10'd0 || first_err_valid !== 1'b0)
      $display("FAIL done_restart: got done=%b busy=%b err=%0d fev=%b expected 0 1 0 0",
               done, busy, err_count, first_err_valid);
    else passed++;
    apply_reset();
  endtask

  task automatic test_settle3();
    int cyc;
    run_sweep(1'b1, 6000, cyc);
    checks++;
    if (cyc != 2560) $display("FAIL settle3_len: got %0d cycles expected 2560", cyc);
    else passed++;
    checks++;
    if (pass3 !== 1'b1 || err3 !== 10'd0)
      $display("FAIL settle3_pass: got pass=%b err=%0d expected pass=1 err=0", pass3, err3);
    else passed++;
    // The same slow comparator is too slow for SETTLE=1.
    mode = 3;
    run_sweep(1'b0, 4000, cyc);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count === 10'd0)
      $display("FAIL settle1_slow: got done=%b pass=%b err=%0d expected done=1 pass=0 err>0",
               done, pass, err_count);
    else passed++;
    apply_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_pass();
    test_bit0_stuck();
    test_logical_inverted();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_settle3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
